eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Frame-level round-robin arbiter that shares the single Ethernet transmit byte stream (data/valid/send into the MAC) between several byte-stream sources, such as the RTP sender and control-packet generators. It grants one source a whole frame at a time, waits for the MAC to be idle, enforces an inter-frame gap, and aborts a stalled frame with a watchdog. It sits between the frame builders and the Ethernet transmitter.

## Interface
- NUM_SRC, 2, number of sources; must be ≥2.
- GAP_CYCLES, 96, idle cycles between frames; must be ≥1.
- TIMEOUT_CYCLES, 4096, cycles without a sampled byte before a frame is aborted; must be ≥1.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; asynchronous, active-low
- req_in  in  NUM_SRC  per-source frame-pending request, level
- data_in  in  8*NUM_SRC  source i byte on [8i+7:8i]
- valid_in  in  NUM_SRC  per-source byte valid
- send_in  in  NUM_SRC  per-source last-byte marker; asserted together with valid on the final byte
- eth_busy_in  in  1  MAC still transmitting
- grant_out  out  NUM_SRC  one-hot grant, registered
- active_src_out  out  $clog2(NUM_SRC)  index of the current/last winner
- data_out  out  8  byte to the MAC
- valid_out  out  1  byte valid to the MAC
- send_out  out  1  last-byte marker to the MAC
- abort_out  out  1  one-cycle pulse on watchdog abort

## Operation
- **States:** IDLE, WAIT_MAC, STREAM, GAP. Reset puts the block in IDLE.
- **IDLE:** if any req_in bit is high, pick the winner round-robin: search from last_src+1 upward, wrapping. Latch the winner into active_src_out, then go to WAIT_MAC.
- **WAIT_MAC:**
  - If the winner's req_in drops, return to IDLE. No grant is issued and last_src is unchanged.
  - Otherwise, when eth_busy_in=0, go to STREAM.
- **STREAM:**
  - grant_out = onehot(winner).
  - Only the winner's valid/data/send are sampled. All other sources' inputs are ignored.
  - A sampled valid & send moves the FSM to GAP and sets last_src = winner.
  - The watchdog counts cycles with no sampled valid and clears on each sampled valid. When it reaches TIMEOUT_CYCLES: pulse abort_out, set last_src = winner, go to GAP.
  - If a sampled send coincides with the timeout, the send wins and no abort is issued.
- **GAP:** count exactly GAP_CYCLES cycles, then go to IDLE. Requests are ignored during GAP.
- **Datapath:** data_out, valid_out and send_out are registered copies of the winner's inputs, sampled only while in STREAM. Outside STREAM: valid_out=0, send_out=0, data_out holds its value.
- **Widths:** the watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits and the gap counter is $clog2(GAP_CYCLES+1) bits. Neither counter wraps; both saturate or clear.
- **Round-robin pointer:** last_src resets to NUM_SRC-1, so source 0 wins first after reset.

## Timing
- **Reset values:** all outputs are 0. grant_out=0, active_src_out=0, state=IDLE, all counters=0.
- **Reset mid-frame:** outputs clear asynchronously. The frame is dropped, with no send_out and no abort_out.
- **Request to grant:** req sampled at edge e gives WAIT_MAC at e. If eth_busy_in=0 is sampled at e+1, the FSM enters STREAM at e+1 and grant_out is high after e+1. Minimum latency is 2 cycles.
- **Data latency:** exactly 1 cycle. A byte sampled at edge k appears on data_out/valid_out after edge k.
- **End of frame:** the last byte and send are sampled at edge k. At that same edge the FSM enters GAP and grant_out drops. send_out=1 with the last byte for exactly the cycle after k.
- **Abort:** abort_out is high for the one cycle following the timeout edge. grant_out drops at the same edge and valid_out=0.
- **Back-to-back frames:** a new grant follows at the earliest GAP_CYCLES+2 cycles after a frame ends.
- **eth_busy_in:** examined only in WAIT_MAC. It is ignored during STREAM.

## Test plan
Bench parameters: NUM_SRC=2, GAP_CYCLES=4, TIMEOUT_CYCLES=16.

1. **Single frame:** release reset, then src0 req with bytes AA, BB, CC, send on CC.
   - Required: grant_out=01 two cycles after req.
   - Required: data_out AA/BB/CC with 1-cycle latency, send_out only with CC, grant_out=00 after send.
2. **Fairness:** src0 and src1 request simultaneously and continuously.
   - Required: grant order src0, src1, src0, …
   - Required: exactly 4 idle cycles plus 2 arbitration cycles between send_out and the next grant.
3. **MAC busy:** eth_busy_in=1 for 10 cycles while src1 requests.
   - Required: no grant until busy falls; grant_out=10 one cycle after busy is sampled low.
4. **Watchdog:** the granted src0 stops driving valid after byte 11.
   - Required: a single abort_out pulse after 16 empty cycles, no send_out, grant dropped.
   - Required: pending src1 is granted after the gap.
5. **Isolation and withdrawal:** non-granted src1 toggles valid/send during a src0 frame, and a separate src1 req drops during WAIT_MAC.
   - Required: src1 bytes never reach data_out.
   - Required: the FSM returns to IDLE with no grant.
6. **Reset mid-frame:** assert rst_n_in=0 during byte 2 of a src1 frame.
   - Required: all outputs 0 immediately.
   - Required: after release, with both requesting, src0 is granted first.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Ethernet MAC byte stream between sources.
// A source owns the stream for a whole frame; a watchdog aborts frames that stall.
module eth_tx_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int GAP_CYCLES     = 96,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int SRC_W         = $clog2(NUM_SRC)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_SRC-1:0]   req_in,
  input  logic [8*NUM_SRC-1:0] data_in,
  input  logic [NUM_SRC-1:0]   valid_in,
  input  logic [NUM_SRC-1:0]   send_in,
  input  logic                 eth_busy_in,
  output logic [NUM_SRC-1:0]   grant_out,
  output logic [SRC_W-1:0]     active_src_out,
  output logic [7:0]           data_out,
  output logic                 valid_out,
  output logic                 send_out,
  output logic                 abort_out
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_MAC, STREAM, GAP} state_t;

  state_t state, next_state;

  logic [SRC_W-1:0] last_src;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] cand;
  logic             found;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             sel_req;
  logic             sel_valid;
  logic             sel_send;
  logic [7:0]       sel_data;
  logic             frame_end;
  logic             timeout;
  logic             gap_done;

  assign sel_req   = req_in[active_src_out];
  assign sel_valid = valid_in[active_src_out];
  assign sel_send  = send_in[active_src_out];
  assign sel_data  = data_in[{active_src_out, 3'b000} +: 8];
  assign frame_end = sel_valid & sel_send;
  // A byte arriving on the timeout cycle keeps the frame alive, so send always beats abort.
  assign timeout   = !sel_valid && (wd_cnt == WD_LAST);
  assign gap_done  = (gap_cnt == GAP_LAST);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int d = 1; d <= NUM_SRC; d++) begin
      cand = SRC_W'((int'(last_src) + d) % NUM_SRC);
      if (!found && req_in[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (|req_in) next_state = WAIT_MAC;
      WAIT_MAC: begin
        if (!sel_req)          next_state = IDLE;
        else if (!eth_busy_in) next_state = STREAM;
      end
      STREAM:   if (frame_end || timeout) next_state = GAP;
      GAP:      if (gap_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_out = '0;
    if (state == STREAM) grant_out[active_src_out] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_src_out <= '0;
      last_src       <= SRC_LAST;
      wd_cnt         <= '0;
      gap_cnt        <= '0;
      data_out       <= '0;
      valid_out      <= 1'b0;
      send_out       <= 1'b0;
      abort_out      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      send_out  <= 1'b0;
      abort_out <= 1'b0;
      case (state)
        IDLE: if (|req_in) active_src_out <= winner;
        STREAM: begin
          valid_out <= sel_valid;
          send_out  <= frame_end;
          if (sel_valid) data_out <= sel_data;
          if (sel_valid || timeout) wd_cnt <= '0;
          else                      wd_cnt <= wd_cnt + 1'b1;
          if (frame_end || timeout) last_src <= active_src_out;
          if (timeout) abort_out <= 1'b1;
        end
        GAP: gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: vector table, directed corner sequences and
// randomized traffic compared cycle by cycle against a frame-level reference model.
module tb_eth_tx_arbiter;

  localparam int NUM_SRC = 2;
  localparam int GAP     = 4;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] data;
  logic [1:0]  valid;
  logic [1:0]  send;
  logic        busy;
  logic [1:0]  grant;
  logic        active;
  logic [7:0]  dout;
  logic        vout;
  logic        sout;
  logic        abort;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  eth_tx_arbiter #(
    .NUM_SRC(NUM_SRC), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .data_in(data),
    .valid_in(valid), .send_in(send), .eth_busy_in(busy),
    .grant_out(grant), .active_src_out(active), .data_out(dout),
    .valid_out(vout), .send_out(sout), .abort_out(abort)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the stream, who is waiting on the MAC, gap cycles left.
  int         m_owner, m_pick, m_gap, m_quiet, m_last;
  logic [1:0] e_grant;
  logic       e_valid, e_send, e_abort;
  logic [7:0] e_data;
  int         e_active;

  task automatic model_reset();
    m_owner = -1; m_pick = -1; m_gap = 0; m_quiet = 0; m_last = NUM_SRC - 1;
    e_grant = '0; e_valid = 0; e_send = 0; e_abort = 0; e_data = '0; e_active = 0;
  endtask

  task automatic model_step();
    bit hit;
    e_valid = 0; e_send = 0; e_abort = 0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner >= 0) begin
      if (valid[m_owner]) begin
        e_valid = 1; e_data = data[8*m_owner +: 8]; e_send = send[m_owner]; m_quiet = 0;
        if (send[m_owner]) begin m_last = m_owner; m_owner = -1; m_gap = GAP; end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          e_abort = 1; m_last = m_owner; m_owner = -1; m_gap = GAP; m_quiet = 0;
        end
      end
    end else if (m_pick >= 0) begin
      if (!req[m_pick]) m_pick = -1;
      else if (!busy) begin m_owner = m_pick; m_pick = -1; m_quiet = 0; end
    end else if (req != 0) begin
      hit = 0;
      for (int d = 1; d <= NUM_SRC; d++) begin
        if (!hit && req[(m_last + d) % NUM_SRC]) begin
          m_pick = (m_last + d) % NUM_SRC; hit = 1;
        end
      end
      e_active = m_pick;
    end
    e_grant = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    check("grant", 32'(grant), 32'(e_grant));
    check("valid_out", 32'(vout), 32'(e_valid));
    check("send_out", 32'(sout), 32'(e_send));
    check("abort_out", 32'(abort), 32'(e_abort));
    check("active_src", 32'(active), 32'(e_active));
    if (e_valid) check("data_out", 32'(dout), 32'(e_data));
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] v, input logic [1:0] s,
                               input logic [7:0] d0, input logic [7:0] d1, input logic b);
    req = r; valid = v; send = s; data = {d1, d0}; busy = b;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic do_reset();
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    check("reset_data", 32'(dout), 32'h0);
    rst_n = 1'b1;
  endtask

  // Finish any frame still in flight, then let the gap expire.
  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      applyStimulus(2'b00, grant, grant, 8'h00, 8'h00, 1'b0);
      tick();
    end
  endtask

  typedef struct {
    logic [1:0] req, valid, send;
    logic [7:0] d0, d1;
    logic [1:0] exp_grant;
    logic       exp_valid, exp_send;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] v, s, prev_g;
    logic [7:0] dd[2];
    int         cnt[2];
    int         order_idx, send_cyc;
    bit         quiet;

    vecs[0] = '{2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00};
    vecs[1] = '{2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 2'b01, 0, 0, 8'h00};
    vecs[2] = '{2'b01, 2'b11, 2'b10, 8'hAA, 8'h55, 2'b01, 1, 0, 8'hAA};
    vecs[3] = '{2'b01, 2'b01, 2'b00, 8'hBB, 8'h66, 2'b01, 1, 0, 8'hBB};
    vecs[4] = '{2'b01, 2'b11, 2'b11, 8'hCC, 8'h77, 2'b00, 1, 1, 8'hCC};
    vecs[5] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00};
    vecs[6] = '{2'b10, 2'b10, 2'b10, 8'h00, 8'h99, 2'b00, 0, 0, 8'h00};
    vecs[7] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00};

    rst_n = 1'b0;
    do_reset();

    // Single src0 frame with src1 noise on its own lanes.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].req, vecs[i].valid, vecs[i].send, vecs[i].d0, vecs[i].d1, 1'b0);
      tick();
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_valid", i), 32'(vout), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_send", i), 32'(sout), 32'(vecs[i].exp_send));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), 32'(dout), 32'(vecs[i].exp_data));
    end
    drain();

    // Fairness: both sources request continuously, 3-byte frames.
    do_reset();
    cnt = '{0, 0};
    order_idx = 0; send_cyc = -1; prev_g = '0;
    for (int c = 0; c < 80; c++) begin
      v = '0; s = '0;
      for (int i = 0; i < 2; i++) begin
        dd[i] = 8'(16 * (i + 1) + cnt[i]);
        if (grant[i]) begin v[i] = 1'b1; s[i] = (cnt[i] == 2); end
      end
      applyStimulus(2'b11, v, s, dd[0], dd[1], 1'b0);
      tick();
      for (int i = 0; i < 2; i++) if (v[i]) cnt[i] = s[i] ? 0 : cnt[i] + 1;
      if (sout) send_cyc = cyc;
      if (grant != 0 && prev_g == 0) begin
        check("fair_order", 32'(grant), (order_idx % 2 == 0) ? 32'h1 : 32'h2);
        if (send_cyc >= 0) check("fair_gap", 32'(cyc - send_cyc), 32'(GAP + 2));
        order_idx++;
      end
      prev_g = grant;
    end
    check("fair_grant_count", 32'(order_idx >= 6), 32'h1);
    drain();

    // MAC busy holds src1 in the waiting phase.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
      tick();
      check("busy_hold_grant", 32'(grant), 32'h0);
    end
    applyStimulus(2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    check("busy_release_grant", 32'(grant), 32'h2);
    applyStimulus(2'b10, 2'b10, 2'b10, 8'h00, 8'h5A, 1'b0);
    tick();
    check("busy_frame_data", 32'(dout), 32'h5A);
    check("busy_frame_send", 32'(sout), 32'h1);
    drain();

    // Watchdog: src0 stalls after 11 bytes while src1 waits.
    applyStimulus(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    check("wd_grant", 32'(grant), 32'h1);
    for (int b = 0; b < 11; b++) begin
      applyStimulus(2'b11, 2'b01, 2'b00, 8'(b + 1), 8'hEE, 1'b0);
      tick();
    end
    for (int q = 1; q <= TMO; q++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      tick();
      check($sformatf("wd_abort_q%0d", q), 32'(abort), (q == TMO) ? 32'h1 : 32'h0);
      check("wd_no_send", 32'(sout), 32'h0);
    end
    check("wd_grant_drop", 32'(grant), 32'h0);
    check("wd_valid_low", 32'(vout), 32'h0);
    for (int c = 1; c <= GAP + 2; c++) begin
      tick();
      if (c == 1) check("wd_abort_single", 32'(abort), 32'h0);
      check("wd_next_grant", 32'(grant), (c == GAP + 2) ? 32'h2 : 32'h0);
    end
    drain();

    // Withdrawal: src1 drops its request while waiting for the MAC.
    applyStimulus(2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      tick();
      check("withdraw_no_grant", 32'(grant), 32'h0);
    end

    // Reset in the middle of a src1 frame.
    applyStimulus(2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    check("mid_grant", 32'(grant), 32'h2);
    applyStimulus(2'b10, 2'b10, 2'b00, 8'h00, 8'h21, 1'b0);
    tick();
    applyStimulus(2'b10, 2'b10, 2'b00, 8'h00, 8'h22, 1'b0);
    tick();
    check("mid_byte2", 32'(dout), 32'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_data", 32'(dout), 32'h0);
    check("mid_rst_vsa", 32'({vout, sout, abort}), 32'h0);
    do_reset();
    applyStimulus(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    check("post_rst_grant", 32'(grant), 32'h1);
    drain();

    // Randomized traffic against the model.
    do_reset();
    quiet = 0;
    v = '0; s = '0;
    req = 2'b00;
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) quiet = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        v[i]  = quiet ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        s[i]  = v[i] && ($urandom_range(0, 5) == 0);
        dd[i] = 8'($urandom);
      end
      applyStimulus(req, v, s, dd[0], dd[1], ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
